// File: rtl/asrv32_mem_responder.sv
// Memory-side responder: word RAM with byte-lane writes, programmable wait states and range errors.
// Optional `ASRV32_MEM_ALIGN_CHECK_EN rejects misaligned addresses and unsupported write lane masks.
module asrv32_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1,
   parameter              INIT_FILE   = ""
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wsel,
   output logic        o_ack,
   output logic        o_err,
   output logic [31:0] o_rdata,
   output logic        o_busy
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        r_state, w_state_d;
   logic [3:0]    r_cnt, w_cnt_d;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wsel;
   logic          r_err;
   logic [31:0]   r_rdata;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_idle;
   logic          w_we;
   logic [31:0]   w_addr;
   logic [31:0]   w_wdata;
   logic [3:0]    w_wsel;
   logic [32:0]   w_diff;
   logic          w_in_range;
   logic [AW-1:0] w_idx;
   logic          w_align_err;
   logic          w_err;
   logic          w_enter_resp;
   logic          w_err_d;
   logic [31:0]   w_rdata_d;

   // With zero wait states the RAM is accessed on the acceptance edge itself, so
   // the live inputs stand in for the not-yet-latched copies while idle.
   assign w_idle  = (r_state == StIdle);
   assign w_we    = w_idle ? i_we    : r_we;
   assign w_addr  = w_idle ? i_addr  : r_addr;
   assign w_wdata = w_idle ? i_wdata : r_wdata;
   assign w_wsel  = w_idle ? i_wsel  : r_wsel;

   // A 33-bit difference goes negative (huge) below BASE_ADDR, so one compare covers both bounds.
   assign w_diff     = {1'b0, w_addr} - {1'b0, BASE_ADDR};
   assign w_in_range = (w_diff < SPAN);
   assign w_idx      = w_diff[AW+1:2];

`ifdef ASRV32_MEM_ALIGN_CHECK_EN
   logic w_wsel_ok;

   always_comb begin
      w_wsel_ok = 1'b0;
      case (w_wsel)
         4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: w_wsel_ok = 1'b1;
         default: w_wsel_ok = 1'b0;
      endcase
   end

   assign w_align_err = (w_addr[1:0] != 2'b00) || (w_we && !w_wsel_ok);
`else
   assign w_align_err = 1'b0;
`endif

   assign w_err = !w_in_range || w_align_err;

   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_enter_resp = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_req) begin
               if (WAIT_STATES == 0) begin
                  w_state_d    = StResp;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_d = StWait;
                  w_cnt_d   = CNT_INIT;
               end
            end
         end
         StWait: begin
            if (r_cnt == 4'd0) begin
               w_state_d    = StResp;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Response qualifiers live for the single RESP cycle only.
   assign w_err_d   = w_enter_resp && w_err;
   assign w_rdata_d = (w_enter_resp && !w_we && !w_err) ? r_mem[w_idx] : 32'h0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_wsel  <= 4'h0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_idle && i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wsel  <= i_wsel;
         end
         r_err   <= w_err_d;
         r_rdata <= w_rdata_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_enter_resp && w_we && !w_err) begin
         for (int k = 0; k < 4; k++) begin
            if (w_wsel[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
         end
      end
   end

   assign o_ack   = (r_state == StResp);
   assign o_busy  = (r_state != StIdle);
   assign o_err   = r_err;
   assign o_rdata = r_rdata;

endmodule
